tx_shift_ctrl: RTL and testbench

//  Sequences the parallel-to-serial transmit shift register in the USB TX path.

---
 rtl/tx_shift_ctrl.sv | 109 ++++++++++
 tb/tb_tx_shift_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/tx_shift_ctrl.sv
// tx_shift_ctrl: sequences the USB TX parallel-to-serial shift register,
// pulling packet bytes from an upstream valid/pop source and pacing one shift per bit period.
module tx_shift_ctrl #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 8,
    parameter int LEN_W        = 7
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 tx_start,
    input  logic [LEN_W-1:0]     tx_len,
    input  logic                 tx_abort,
    input  logic                 tx_byte_valid,
    input  logic [DATA_BITS-1:0] tx_byte,
    output logic                 tx_byte_pop,
    output logic                 pts_load,
    output logic                 pts_shift,
    output logic [DATA_BITS-1:0] pts_data,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_underrun
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_BITS);
    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, DONE, ERR} state_t;
    state_t           state, state_nx;
    logic [CW-1:0]    clk_cnt, clk_cnt_nx;
    logic [BW-1:0]    bit_cnt, bit_cnt_nx;
    logic [LEN_W-1:0] bytes_left, bytes_left_nx;
    logic             last_clk, last_bit;
    assign last_clk = clk_cnt == CW'(CLKS_PER_BIT - 1);
    assign last_bit = bit_cnt == BW'(DATA_BITS - 1);
    assign pts_data = tx_byte;
    assign pts_load = tx_byte_pop;
    assign tx_busy  = state != IDLE;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            bytes_left <= '0;
        end else begin
            state      <= state_nx;
            clk_cnt    <= clk_cnt_nx;
            bit_cnt    <= bit_cnt_nx;
            bytes_left <= bytes_left_nx;
        end
    end
    always_comb begin
        state_nx      = state;
        clk_cnt_nx    = clk_cnt;
        bit_cnt_nx    = bit_cnt;
        bytes_left_nx = bytes_left;
        tx_byte_pop   = 1'b0;
        pts_shift     = 1'b0;
        tx_done       = 1'b0;
        tx_underrun   = 1'b0;
        case (state)
            IDLE: begin
                if (tx_start) begin
                    bytes_left_nx = tx_len;
                    state_nx      = tx_len != '0 ? FETCH : DONE;
                end
            end
            FETCH: begin
                if (tx_abort) begin
                    state_nx = IDLE;
                end else if (tx_byte_valid) begin
                    tx_byte_pop   = 1'b1;
                    bytes_left_nx = bytes_left - LEN_W'(1);
                    clk_cnt_nx    = '0;
                    bit_cnt_nx    = '0;
                    state_nx      = SHIFT;
                end
            end
            SHIFT: begin
                if (tx_abort) begin
                    state_nx = IDLE;
                end else begin
                    clk_cnt_nx = last_clk ? '0 : clk_cnt + CW'(1);
                    if (last_clk && !last_bit) begin
                        pts_shift  = 1'b1;
                        bit_cnt_nx = bit_cnt + BW'(1);
                    end else if (last_clk) begin
                        // Byte boundary: reload back-to-back, or stop holding the final bit
                        if (bytes_left == '0) begin
                            state_nx = DONE;
                        end else if (tx_byte_valid) begin
                            tx_byte_pop   = 1'b1;
                            bytes_left_nx = bytes_left - LEN_W'(1);
                            bit_cnt_nx    = '0;
                        end else begin
                            state_nx = ERR;
                        end
                    end
                end
            end
            DONE: begin
                tx_done  = !tx_abort;
                state_nx = IDLE;
            end
            ERR: begin
                tx_underrun = !tx_abort;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_tx_shift_ctrl.sv
// tb_tx_shift_ctrl: directed packet scenarios with a byte scoreboard and per-cycle
// expected control waveforms derived from the packet timing formulas.
module tb_tx_shift_ctrl;
    localparam int DB  = 8;
    localparam int CPB = 4;
    localparam int LW  = 7;
    localparam int BP  = DB * CPB;
    logic          clk = 0, n_rst = 0, tx_start = 0, tx_abort = 0, tx_byte_valid = 0;
    logic [LW-1:0] tx_len = '0;
    logic [DB-1:0] tx_byte = '0;
    logic          tx_byte_pop, pts_load, pts_shift, tx_busy, tx_done, tx_underrun;
    logic [DB-1:0] pts_data;
    int            vectors = 0, miscompares = 0;
    logic [DB-1:0] sb_q[$];
    logic [DB-1:0] bytes[4];
    int            n, d, miss, ab, sb, rc;

    always #5 clk = ~clk;

    tx_shift_ctrl #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .LEN_W(LW)) dut (
        .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_len(tx_len), .tx_abort(tx_abort),
        .tx_byte_valid(tx_byte_valid), .tx_byte(tx_byte), .tx_byte_pop(tx_byte_pop),
        .pts_load(pts_load), .pts_shift(pts_shift), .pts_data(pts_data), .tx_busy(tx_busy),
        .tx_done(tx_done), .tx_underrun(tx_underrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // {busy, pop, shift, done, underrun} expected in cycle c (tx_start in cycle 0)
    function automatic logic [4:0] expv(int c);
        int       k, e, r;
        logic     b, p, s, dn, u;
        k  = miss > 0 ? miss : n;
        e  = 1 + BP * k;
        r  = c - 1 - d;
        b  = c >= 1 && r <= e;
        p  = r >= 0 && r % BP == 0 && r / BP < k;
        s  = r >= 1 && r < e && (r - 1) % CPB == CPB - 1 && ((r - 1) / CPB) % DB != DB - 1;
        dn = miss == 0 && r == e;
        u  = miss > 0 && r == e;
        if (ab > 0 && c == ab) {p, s, dn, u} = 4'b0;
        if (ab > 0 && c > ab) {b, p, s, dn, u} = 5'b0;
        return {b, p, s, dn, u};
    endfunction

    task automatic do_reset();
        tx_start = 0; tx_abort = 0; tx_byte_valid = 0; tx_byte = '0;
        #1 n_rst = 0;
        #1 chk("async_reset_outs", {tx_busy, tx_byte_pop, pts_load, pts_shift, tx_done, tx_underrun}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) n_rst = 1;
        @(negedge clk) chk("post_reset_idle", {tx_busy, tx_byte_pop, pts_shift, tx_done}, 0);
    endtask

    task automatic run_pkt(input string name);
        int            last, idx, pops;
        logic [4:0]    ev;
        logic [DB-1:0] eb;
        sb_q.delete();
        for (int i = 0; i < n; i++) sb_q.push_back(bytes[i]);
        idx  = 0;
        pops = 0;
        last = 2 + d + BP * (miss > 0 ? miss : n) + 3;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk);
            #1;
            tx_start      = c == 0 || (sb > 0 && c == sb);
            tx_len        = c == 0 ? LW'(n) : LW'(1);
            tx_abort      = ab > 0 && c == ab;
            tx_byte_valid = c > d && !(miss > 0 && c == 1 + d + BP * miss) && idx < n;
            tx_byte       = idx < n ? bytes[idx] : '0;
            if (rc > 0 && c == rc) begin
                do_reset();
                sb_q.delete();
                return;
            end
            @(negedge clk);
            ev = expv(c);
            pops += int'(ev[3]);
            chk($sformatf("%s_ctl_c%0d", name, c),
                {tx_busy, tx_byte_pop, pts_shift, tx_done, tx_underrun}, ev);
            chk($sformatf("%s_loadpop_c%0d", name, c), pts_load, tx_byte_pop);
            if (tx_byte_pop) begin
                if (sb_q.size() == 0) begin
                    chk($sformatf("%s_extra_pop_c%0d", name, c), 1, 0);
                end else begin
                    eb = sb_q.pop_front();
                    chk($sformatf("%s_byte_c%0d", name, c), pts_data, eb);
                    idx++;
                end
            end
        end
        chk({name, "_leftover"}, sb_q.size(), n - pops);
        tx_start = 0; tx_abort = 0; tx_byte_valid = 0;
    endtask

    task automatic setup(input int nn, input int dd, input int mm, input int aa, input int ss, input int rr);
        n = nn; d = dd; miss = mm; ab = aa; sb = ss; rc = rr;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 chk("reset_outs", {tx_busy, tx_byte_pop, pts_load, pts_shift, tx_done, tx_underrun}, 0);
        @(negedge clk) n_rst = 1;

        bytes[0] = 8'hA5;
        setup(1, 0, 0, 0, 0, 0); run_pkt("single");

        bytes[0] = 8'h01; bytes[1] = 8'h80; bytes[2] = 8'hFF;
        setup(3, 0, 0, 0, 10, 0); run_pkt("three_busy_start");

        bytes[0] = 8'h3C; bytes[1] = 8'hC3;
        setup(2, 0, 1, 0, 0, 0); run_pkt("underrun");

        bytes[0] = 8'hA5;
        setup(1, 0, 0, 10, 0, 0); run_pkt("abort_mid");
        setup(1, 0, 0, 0, 0, 0); run_pkt("after_abort");

        setup(1, 0, 0, 34, 0, 0); run_pkt("abort_in_done");

        bytes[0] = 8'h5A; bytes[1] = 8'h96;
        setup(2, 0, 0, 33, 0, 0); run_pkt("abort_at_boundary");

        setup(2, 5, 0, 0, 0, 0); run_pkt("fetch_wait");

        @(posedge clk);
        #1 tx_start = 1; tx_len = '0; tx_byte_valid = 1; tx_byte = 8'h77;
        @(negedge clk) chk("len0_c0", {tx_busy, tx_byte_pop, tx_done}, 3'b000);
        @(posedge clk);
        #1 tx_start = 0;
        @(negedge clk) chk("len0_c1", {tx_busy, tx_byte_pop, tx_done}, 3'b101);
        @(negedge clk) chk("len0_c2", {tx_busy, tx_byte_pop, tx_done}, 3'b000);
        tx_byte_valid = 0;

        bytes[0] = 8'hA5;
        setup(1, 0, 0, 0, 0, 15); run_pkt("reset_mid");
        setup(1, 0, 0, 0, 0, 0); run_pkt("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
